// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM single-cycle fetch path.
// Used by fetch_unit and pc_reg.
package arm_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      FETCH,
      EXEC,
      FAULT
   } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC mux (branch target or PC+4).
// Reusable by a later multicycle variant.
module pc_reg
   import arm_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              sel_i,
   input  logic [WORD_W-1:2] target_i,
   output logic [WORD_W-1:0] pc_o,
   output logic [WORD_W-1:0] pc_plus4_o
);

   logic [WORD_W-1:0] pc_q, pc_d;

   assign pc_plus4_o = pc_q + PC_INC;
   assign pc_o       = pc_q;

   always_comb begin
      pc_d = pc_q;
      if (en_i) begin
         pc_d = sel_i ? {target_i, 2'b00} : pc_plus4_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH/EXEC/FAULT sequencer with imem wait timeout.
// Define FETCH_PERF_EN to add the retired/stall_cycles counters.
module fetch_unit
   import arm_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int                MAX_WAIT     = 15
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              imem_ready,
   input  logic              PCSrc,
   input  logic [WORD_W-1:0] Result,
   output logic [WORD_W-1:0] Instr,
   output logic              instr_valid,
   output logic [WORD_W-1:0] PC,
   output logic [WORD_W-1:0] PCPlus4,
   output logic [WORD_W-1:0] PCPlus8,
`ifdef FETCH_PERF_EN
   output logic [WORD_W-1:0] retired,
   output logic [WORD_W-1:0] stall_cycles,
`endif
   output logic              fault
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   fetch_state_t      state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic [WORD_W-1:0] instr_q, instr_d;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      instr_d = instr_q;
      unique case (state_q)
         FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               wait_d  = '0;
               state_d = EXEC;
            end else begin
               wait_d = wait_q + 8'd1;
               // MAX_WAIT-th consecutive miss ends the fetch
               if (wait_q == WAIT_LAST) begin
                  state_d = FAULT;
               end
            end
         end
         EXEC:    state_d = FETCH;
         FAULT:   state_d = FAULT;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         wait_q  <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         instr_q <= instr_d;
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign instr_valid = (state_q == EXEC);
   assign fault       = (state_q == FAULT);
   assign Instr       = instr_q;
   assign imem_addr   = PC;
   assign PCPlus8     = PCPlus4 + PC_INC;

   pc_reg #(
      .RESET_VECTOR(RESET_VECTOR)
   ) u_pc (
      .clk_i      (clk),
      .rst_ni     (reset),
      .en_i       (instr_valid),
      .sel_i      (PCSrc),
      .target_i   (Result[WORD_W-1:2]),
      .pc_o       (PC),
      .pc_plus4_o (PCPlus4)
   );

`ifdef FETCH_PERF_EN
   logic [WORD_W-1:0] retired_q, stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (instr_valid) begin
            retired_q <= retired_q + 32'd1;
         end
         if (imem_req && !imem_ready) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign retired      = retired_q;
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized imem latency and branches.
// Define FETCH_PERF_EN to also check the performance counters.
module tb_fetch_unit;

   localparam logic [31:0] RV = 32'h0000_0100;
   localparam int          MW = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic        PCSrc;
   logic [31:0] Result, Instr, PC, PCPlus4, PCPlus8;
   logic        instr_valid, fault;
`ifdef FETCH_PERF_EN
   logic [31:0] retired, stall_cycles;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_VECTOR(RV),
      .MAX_WAIT    (MW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .PCSrc       (PCSrc),
      .Result      (Result),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .PCPlus8     (PCPlus8),
`ifdef FETCH_PERF_EN
      .retired     (retired),
      .stall_cycles(stall_cycles),
`endif
      .fault       (fault)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          t;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [31:0] ref_pc;
   logic [31:0] last_instr;
   int          n_ret = 0;
   int          n_stall = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every FETCH/EXEC cycle against the queued transaction
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("fault_low", {31'd0, fault}, 32'd0);
         chk("req_xor_valid", {31'd0, imem_req ^ instr_valid}, 32'd1);
         if (imem_req) begin
            if (q.size() == 0) chk("fetch_queue", 32'(q.size()), 32'd1);
            else begin
               chk("imem_addr", imem_addr, q[0].addr);
               chk("instr_hold", Instr, last_instr);
            end
         end
         if (instr_valid) begin
            if (q.size() == 0) chk("exec_queue", 32'(q.size()), 32'd1);
            else begin
               e = q.pop_front();
               chk("Instr", Instr, e.data);
               chk("PC", PC, e.addr);
               chk("PCPlus4", PCPlus4, e.addr + 32'd4);
               chk("PCPlus8", PCPlus8, e.addr + 32'd8);
               chk("exec_cycle", 32'(cyc), 32'(e.t));
               last_instr = e.data;
            end
         end
      end
   end

   // One instruction: n wait cycles, handshake, then EXEC with branch choice
   task automatic do_instr(input int n, input logic [31:0] data,
                           input bit br, input logic [31:0] tgt);
      exp_t e;
      e.addr = ref_pc;
      e.data = data;
      e.t    = cyc + n + 1;
      q.push_back(e);
      for (int i = 0; i < n; i++) begin
         imem_ready = 1'b0;
         imem_rdata = $urandom;
         PCSrc      = 1'b1;
         Result     = $urandom;
         @(posedge clk); #1;
      end
      imem_ready = 1'b1;
      imem_rdata = data;
      PCSrc      = 1'b1;
      Result     = $urandom;
      @(posedge clk); #1;
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      PCSrc      = br;
      Result     = tgt;
      @(posedge clk); #1;
      ref_pc = br ? (tgt & ~32'h3) : ref_pc + 32'd4;
      n_ret++;
      n_stall += n;
   endtask

   initial begin
      reset      = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = '0;
      PCSrc      = 1'b0;
      Result     = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd1);
      chk("rst_addr", imem_addr, RV);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_instr", Instr, 32'd0);

      @(posedge clk); #1;
      reset      = 1'b1;
      ref_pc     = RV;
      last_instr = '0;
      #1;
      chk("rel_addr", imem_addr, RV);
      chk("rel_req", {31'd0, imem_req}, 32'd1);
      mon_en = 1'b1;

      do_instr(0, 32'hE3A0_1005, 1'b0, 32'd0);
      do_instr(3, $urandom, 1'b1, 32'h0000_0203);
      do_instr(MW - 1, $urandom, 1'b0, 32'd0);
      for (int i = 0; i < 30; i++) begin
         do_instr(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, MW - 1),
                  $urandom, ($urandom_range(0, 3) == 0), $urandom);
      end
      do_instr(0, $urandom, 1'b1, 32'hFFFF_FFFF);
      do_instr(1, $urandom, 1'b0, 32'd0);
      do_instr(0, $urandom, 1'b1, 32'h0000_0204);

      mon_en     = 1'b0;
      imem_ready = 1'b0;
      chk("queue_empty", 32'(q.size()), 32'd0);
`ifdef FETCH_PERF_EN
      chk("retired", retired, 32'(n_ret));
      chk("stall_cycles", stall_cycles, 32'(n_stall));
`endif

      @(negedge clk);
      chk("pre_rst_addr", imem_addr, 32'h0000_0204);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("async_pc", PC, RV);
      chk("async_req", {31'd0, imem_req}, 32'd1);
      chk("async_instr", Instr, 32'd0);
      chk("async_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
      chk("rst_retired", retired, 32'd0);
      chk("rst_stall", stall_cycles, 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 1; i <= MW; i++) begin
         @(negedge clk);
         chk("wait_no_fault", {31'd0, fault}, 32'd0);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, RV);
      end
      @(negedge clk);
      chk("fault_set", {31'd0, fault}, 32'd1);
      chk("fault_req", {31'd0, imem_req}, 32'd0);
`ifdef FETCH_PERF_EN
      chk("fault_stall", stall_cycles, 32'(MW));
`endif
      imem_ready = 1'b1;
      PCSrc      = 1'b1;
      Result     = 32'h0000_0800;
      repeat (4) begin
         @(negedge clk);
         chk("fault_sticky", {31'd0, fault}, 32'd1);
         chk("fault_valid", {31'd0, instr_valid}, 32'd0);
         chk("fault_pc", PC, RV);
      end

      #2;
      reset = 1'b0;
      #1;
      chk("fault_clr", {31'd0, fault}, 32'd0);
      chk("fault_rst_pc", PC, RV);
      @(posedge clk); #1;
      reset      = 1'b1;
      ref_pc     = RV;
      last_instr = '0;
      n_ret      = 0;
      n_stall    = 0;
      mon_en     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_instr($urandom_range(0, 2), $urandom, 1'b0, 32'd0);
      end
      mon_en = 1'b0;
      chk("final_queue", 32'(q.size()), 32'd0);
`ifdef FETCH_PERF_EN
      chk("retired_restart", retired, 32'(n_ret));
      chk("stall_restart", stall_cycles, 32'(n_stall));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the ARM single-cycle processor, directly upstream of the control unit and datapath. It holds the PC and fetches from instruction memory through a valid/ready handshake that tolerates wait states. It latches the word into an instruction register and presents it for exactly one execute cycle. At the end of that cycle it applies the branch decision from condition logic (PCSrc/Result).

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- MAX_WAIT, 15, maximum imem wait cycles tolerated before fault; range 1..255.

Ports:
- clk  in  1  system clock; one clock, all state on rising edge.
- reset  in  1  reset is asynchronous and active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, equal to PC, word aligned.
- imem_rdata  in  32  instruction word, sampled when imem_req and imem_ready.
- imem_ready  in  1  memory accepts the request and returns data this cycle.
- PCSrc  in  1  from condition logic; take branch/PC write.
- Result  in  32  branch target or PC write value; bits [1:0] ignored.
- Instr  out  32  instruction register, feeding controller Instr[31:12] and datapath.
- instr_valid  out  1  execute cycle; datapath and register-file writes are qualified by it.
- PC  out  32  current PC.
- PCPlus4  out  32  PC+4, the link value for BrL.
- PCPlus8  out  32  PC+8, the R15 read value.
- fault  out  1  sticky fetch timeout.

## Operation
- FSM states: FETCH, EXEC, FAULT. Reset state is FETCH.
- **FETCH**
  - imem_req=1 and imem_addr=PC.
  - On imem_ready: Instr<=imem_rdata, wait counter cleared, next state EXEC.
  - Otherwise the wait counter increments.
  - When the counter reaches MAX_WAIT without imem_ready, next state FAULT.
- **EXEC**
  - imem_req=0 and instr_valid=1 for exactly one cycle.
  - At the closing edge, PC <= PCSrc ? {Result[31:2],2'b00} : PC+4, then next state FETCH.
- **FAULT**
  - Terminal until reset. fault=1, imem_req=0, instr_valid=0, PC frozen.
- Arithmetic is modulo 2^32.
  - PC+4 wraps from 32'hFFFF_FFFC to 0 with no flag.
  - PCPlus4 and PCPlus8 are combinational from PC and wrap likewise.
- PCSrc and Result are ignored outside EXEC.
- imem_ready outside FETCH is ignored.
- imem_rdata is captured only on the handshake edge. Instr holds its value through FETCH of the next instruction.
- Reset values: PC=RESET_VECTOR, Instr=0, instr_valid=0, imem_req=1 (FETCH), fault=0, wait counter=0.
- Reset asserted mid-fetch or mid-exec aborts immediately and asynchronously. The pending request is dropped, and no PC update or Instr capture occurs.

## Timing
- Zero-wait memory: FETCH 1 cycle, EXEC 1 cycle, giving 2 cycles per instruction.
- With N wait cycles (imem_ready low for N cycles), throughput is N+2 cycles per instruction.
- Fault is entered on the edge after MAX_WAIT consecutive non-ready FETCH cycles. fault is high on the following cycle.
- instr_valid and imem_req are decoded from the registered state only; they have no combinational path from inputs.
- imem_addr is stable for the whole FETCH state.

## Configuration
- FETCH_PERF_EN defined:
  - Adds output retired (32 bits), reset to 0.
  - Increments on every EXEC cycle and wraps modulo 2^32.
  - Also adds output stall_cycles (32 bits), which counts FETCH cycles with imem_ready low.
- FETCH_PERF_EN undefined: both ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package (arm_pkg):
  - fetch_state_t enum {FETCH, EXEC, FAULT}.
  - WORD_W=32.
  - PC_INC=4.
- Single module. An optional sub-module, pc_reg (PC register with async active-low reset and next-PC mux), is natural and reusable for a later multicycle variant.

## Test plan
- Reset with RESET_VECTOR=32'h100, release -> imem_req=1, imem_addr=32'h100, instr_valid=0, fault=0.
- Zero-wait memory returning 32'hE3A0_1005 at 0x100 -> Instr=32'hE3A01005 with instr_valid=1 in cycle 2. Next fetch at 0x104, PCPlus8=0x108 during EXEC.
- imem_ready delayed 3 cycles -> imem_addr held constant 4 cycles; EXEC follows, 5 cycles per instruction.
- EXEC with PCSrc=1, Result=32'h0000_0203 -> next imem_addr=32'h200. PCSrc=1 during FETCH has no effect.
- imem_ready held low with MAX_WAIT=15 -> fault=1 after cycle 15, imem_req=0 permanently. Reset clears fault and restarts at RESET_VECTOR.
- Reset pulsed mid-FETCH with PC=0x204 -> PC=RESET_VECTOR immediately. With FETCH_PERF_EN, retired=0 and increments once per instruction.
